// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision adder front end: field widths,
// packed-operand field positions and the alignment-stage state encoding.
package fp_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 23;
    localparam int FP_BIAS   = 127;

    // Packed operand layout {sign, exp, frac}
    localparam int FP_OP_W     = 1 + FP_EXP_W + FP_MANT_W;
    localparam int FP_FRAC_LSB = 0;
    localparam int FP_EXP_LSB  = FP_MANT_W;
    localparam int FP_SIGN_POS = FP_EXP_W + FP_MANT_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } fp_state_e;

endpackage : fp_pkg

// File: rtl/fp_unpack.sv
// Splits a packed operand into sign, effective exponent and the significand
// with its hidden bit restored. Denormals (exp field 0) get hidden bit 0 and
// an effective exponent of 1 so they line up with the smallest normals.
module fp_unpack
    import fp_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int MANT_W = FP_MANT_W
) (
    input  logic [EXP_W+MANT_W:0] i_op,
    output logic                  o_sign,
    output logic [EXP_W-1:0]      o_exp,
    output logic [MANT_W:0]       o_mant
);

    logic [EXP_W-1:0] exp_field;
    logic             hidden;

    // Field slicing and denormal handling; Inf/NaN pass through as plain values
    always_comb begin
        exp_field = i_op[MANT_W +: EXP_W];
        hidden    = |exp_field;
        o_sign    = i_op[EXP_W+MANT_W];
        o_exp     = hidden ? exp_field : EXP_W'(1);
        o_mant    = {hidden, i_op[MANT_W-1:0]};
    end

endmodule : fp_unpack

// File: rtl/fp_align_stage.sv
// Exponent-alignment stage in front of the complement adder.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | ready for a new operand pair; outputs hold last result
//   SHIFT | smaller significand shifted right one bit per cycle
//   DONE  | aligned result presented, waiting for downstream to take it
//
// Operand 1 is always the larger effective exponent (A on a tie). Shifts of
// MANT_W+1 or more collapse in the capture cycle: the whole significand
// becomes sticky, so the one-bit-per-cycle loop never exceeds MANT_W steps.
module fp_align_stage
    import fp_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int MANT_W = FP_MANT_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [EXP_W+MANT_W:0] i_a,
    input  logic [EXP_W+MANT_W:0] i_b,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_sign1,
    output logic                  o_sign2,
    output logic [MANT_W:0]       o_mant1,
    output logic [MANT_W:0]       o_mant2,
    output logic [EXP_W-1:0]      o_exp,
    output logic                  o_sticky
);

    localparam int               CNT_W = $clog2(MANT_W + 2);
    localparam logic [EXP_W-1:0] SAT_D = EXP_W'(MANT_W + 1);

    // Unpacked operands
    logic              a_sign, b_sign;
    logic [EXP_W-1:0]  a_exp, b_exp;
    logic [MANT_W:0]   a_mant, b_mant;

    // Values loaded on capture
    logic              swap_d;
    logic              sign1_d, sign2_d;
    logic [EXP_W-1:0]  exp1_d, exp2_d;
    logic [MANT_W:0]   mant1_d, mant2_d;
    logic [EXP_W-1:0]  diff_d;
    logic              sat_d;
    logic [CNT_W-1:0]  cnt_d;

    // Registered state and outputs
    fp_state_e         state_q;
    logic              ready_q;
    logic              valid_q;
    logic              sign1_q, sign2_q;
    logic [MANT_W:0]   mant1_q, mant2_q;
    logic [EXP_W-1:0]  exp_q;
    logic              sticky_q;
    logic [CNT_W-1:0]  cnt_q;

    fp_unpack #(
        .EXP_W  (EXP_W),
        .MANT_W (MANT_W)
    ) u_unpack_a (
        .i_op   (i_a),
        .o_sign (a_sign),
        .o_exp  (a_exp),
        .o_mant (a_mant)
    );

    fp_unpack #(
        .EXP_W  (EXP_W),
        .MANT_W (MANT_W)
    ) u_unpack_b (
        .i_op   (i_b),
        .o_sign (b_sign),
        .o_exp  (b_exp),
        .o_mant (b_mant)
    );

    // Order operands by exponent and size the shift; difference is always
    // larger minus smaller so it cannot wrap
    always_comb begin
        swap_d  = (b_exp > a_exp);
        sign1_d = swap_d ? b_sign : a_sign;
        sign2_d = swap_d ? a_sign : b_sign;
        exp1_d  = swap_d ? b_exp  : a_exp;
        exp2_d  = swap_d ? a_exp  : b_exp;
        mant1_d = swap_d ? b_mant : a_mant;
        mant2_d = swap_d ? a_mant : b_mant;
        diff_d  = exp1_d - exp2_d;
        sat_d   = (diff_d >= SAT_D);
        cnt_d   = CNT_W'(diff_d);
    end

    // Sequencer and alignment datapath
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            mant1_q  <= '0;
            mant2_q  <= '0;
            exp_q    <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        ready_q <= 1'b0;
                        sign1_q <= sign1_d;
                        sign2_q <= sign2_d;
                        mant1_q <= mant1_d;
                        exp_q   <= exp1_d;
                        cnt_q   <= '0;
                        if (sat_d) begin
                            mant2_q  <= '0;
                            sticky_q <= |mant2_d;
                            valid_q  <= 1'b1;
                            state_q  <= DONE;
                        end else if (diff_d == '0) begin
                            mant2_q  <= mant2_d;
                            sticky_q <= 1'b0;
                            valid_q  <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            mant2_q  <= mant2_d;
                            sticky_q <= 1'b0;
                            cnt_q    <= cnt_d;
                            state_q  <= SHIFT;
                        end
                    end
                end

                SHIFT: begin
                    mant2_q  <= mant2_q >> 1;
                    sticky_q <= sticky_q | mant2_q[0];
                    cnt_q    <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end
                end

                DONE: begin
                    if (i_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end

                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_ready  = ready_q;
    assign o_valid  = valid_q;
    assign o_sign1  = sign1_q;
    assign o_sign2  = sign2_q;
    assign o_mant1  = mant1_q;
    assign o_mant2  = mant2_q;
    assign o_exp    = exp_q;
    assign o_sticky = sticky_q;

endmodule : fp_align_stage

// File: doc/fp_align_stage.md
Name: fp_align_stage

Overview:
- Pre-add exponent-alignment stage for the single-precision FP adder datapath.
- Accepts two packed IEEE-754 operands through a valid/ready handshake and unpacks them.
- Swaps the operands so that operand 1 has the larger exponent, then right-shifts the smaller significand one bit per cycle.
- Presents the signs, the aligned (MANT_W+1)-bit significands, the common exponent and a sticky bit directly to the complement adder, which is instantiated with WIDTH = MANT_W+1.

Parameters:
- EXP_W, 8, exponent field width.
- MANT_W, 23, stored fraction width. Output significands are MANT_W+1 bits wide and include the hidden bit.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  upstream operand pair valid.
- o_ready  out  1  stage can accept a pair.
- i_a  in  1+EXP_W+MANT_W  operand A, packed {sign, exp, frac}.
- i_b  in  1+EXP_W+MANT_W  operand B, packed {sign, exp, frac}.
- o_valid  out  1  aligned result valid.
- i_ready  in  1  downstream (adder/normaliser) accepts the result.
- o_sign1  out  1  sign of the larger-exponent operand.
- o_sign2  out  1  sign of the shifted operand.
- o_mant1  out  MANT_W+1  unshifted significand.
- o_mant2  out  MANT_W+1  aligned (shifted) significand.
- o_exp  out  EXP_W  common exponent, equal to the larger effective exponent.
- o_sticky  out  1  OR of every bit shifted out of o_mant2.

Behaviour:
- Reset (asynchronous, active-low, effective mid-operation):
  - state is IDLE;
  - all registered outputs are 0 and o_valid = 0;
  - any in-flight pair is discarded.
- Unpack rule:
  - exp != 0: hidden bit = 1, effective exponent = exp.
  - exp == 0: hidden bit = 0, effective exponent = 1 (denormal).
  - exp all-ones (Inf/NaN) is treated as an ordinary value; special-case handling is out of scope.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - o_ready = 1.
  - On i_valid & o_ready, capture the pair.
  - If effB > effA, swap so that operand 1 is B. On a tie, operand 1 is A.
  - d = eff1 - eff2, width EXP_W.
  - d == 0: next state DONE.
  - d >= MANT_W+1: saturate. mant2 becomes 0 and sticky becomes OR(mant2), both in the capture cycle. Next state DONE.
  - Otherwise: cnt <= d, next state SHIFT.
- SHIFT:
  - Each cycle: mant2 <= mant2 >> 1; sticky <= sticky | mant2[0]; cnt <= cnt - 1.
  - When cnt == 1, next state is DONE.
  - o_ready = 0.
- DONE:
  - o_valid = 1; all outputs are held stable.
  - If i_ready, go to IDLE next cycle. An input is never accepted in the same cycle.
  - o_ready = 0.
- Latency from the accept edge to o_valid = 1 is 1 + d cycles, or 1 cycle when saturated. The maximum is MANT_W+1 cycles.
- Back-pressure: while i_ready = 0 the stage holds indefinitely in DONE with stable outputs.
- Input held with i_valid while the stage is busy is ignored (not captured) until the stage returns to IDLE.
- cnt width is clog2(MANT_W+2). No arithmetic wraps: d is computed only as larger minus smaller.

Decomposition:
- Shared package fp_pkg holds:
  - EXP_W, MANT_W, BIAS = 127;
  - the state enum {IDLE, SHIFT, DONE};
  - a field-select function or localparams for packed operand slicing.
- One combinational sub-module, fp_unpack: packed operand in; sign, effective exponent and hidden-bit significand out. It is instantiated twice.

Test Plan:
- Exponent diff 1: A = 0x3F800000 (1.0), B = 0x3F000000 (0.5).
  - Expect o_mant1 = 0x800000, o_mant2 = 0x400000, o_exp = 127, o_sticky = 0.
  - o_valid rises 2 cycles after accept.
- Equal exponents, opposite signs: A = 0x40000000, B = 0xC0000000.
  - Expect o_mant1 = o_mant2 = 0x800000, o_sign1 = 0, o_sign2 = 1, o_exp = 128.
  - Latency 1.
- Swap: A = 0x3F000000 (0.5), B = 0x40400000 (3.0).
  - Expect o_mant1 = 0xC00000, o_exp = 128, o_mant2 = 0x200000.
  - Latency 3.
- Saturation: A = 0x4B800000 (exp 151), B = 0x3F800001 (exp 127, d = 24).
  - Expect o_mant2 = 0, o_sticky = 1.
  - Latency 1.
- Sticky plus back-pressure: A = 0x3F800000, B = 0x3F000001, with i_ready held low for 5 cycles.
  - Expect o_mant2 = 0x400000 and o_sticky = 1, held stable with o_valid = 1 and o_ready = 0 throughout.
  - Return to IDLE one cycle after i_ready rises.
- Reset mid-shift: A = 0x4B000000, B = 0x3F800000 (d = 23). Assert i_rst_n = 0 during the 5th SHIFT cycle.
  - Expect all outputs 0 immediately, o_valid = 0.
  - After release, o_ready = 1 and a new pair is accepted normally.
